// File: rtl/gpu_scroll_engine_if.sv
// Bus between the scroll engine (master) and the gpu slave port.
//   m_write   : write request, master -> gpu
//   m_address : byte address, master -> gpu
//   m_data    : write data, master -> gpu
//   m_stall   : gpu stall; a transfer completes when m_write=1 and m_stall=0
interface gpu_scroll_engine_if;
  logic        m_write;
  logic [23:0] m_address;
  logic [31:0] m_data;
  logic        m_stall;

  modport master (output m_write, output m_address, output m_data, input m_stall);
  modport slave  (input m_write, input m_address, input m_data, output m_stall);
endinterface

// File: rtl/gpu_scroll_engine.sv
// Scrolls the 800x600 1bpp circular framebuffer up by N lines: fills the lines that wrap
// to the bottom with a pattern, then programs the new word offset into REG_PIX_OFFSET.
// Ports:
//   clk, rst      : bus clock, asynchronous active-high reset
//   start         : 1-cycle request, ignored while busy
//   lines         : number of pixel lines to scroll, sampled on start
//   fill_pattern  : word written to the cleared lines, sampled on start
//   busy          : high from the cycle after an accepted start through the done cycle
//   done          : 1-cycle pulse at the end of the sequence
//   cur_offset    : word offset currently programmed into the gpu
//   bus           : master side of the gpu write bus
module gpu_scroll_engine #(
  parameter int unsigned FB_WORDS     = 15000,
  parameter int unsigned LINE_WORDS   = 25,
  parameter logic [23:0] OFF_REG_ADDR = 24'h050000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [9:0]                 lines,
  input  logic [31:0]                fill_pattern,
  output logic                       busy,
  output logic                       done,
  output logic [13:0]                cur_offset,
  gpu_scroll_engine_if.master        bus
);

  localparam int unsigned OFF_W = 14;
  localparam int unsigned SUM_W = 15;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CLEAR  = 2'd1;
  localparam logic [1:0] SETOFF = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]       state, state_d;
  logic [OFF_W-1:0] cnt, cnt_d;
  logic [OFF_W-1:0] idx, idx_d;
  logic [31:0]      pat, pat_d;
  logic [OFF_W-1:0] new_off, new_off_d;
  logic [OFF_W-1:0] cur_offset_d;
  logic             m_write_d;
  logic [23:0]      m_address_d;
  logic [31:0]      m_data_d;
  logic             busy_d, done_d;

  // Start-time values: clamped word count and wrapped target offset (15-bit sums cannot overflow)
  logic [SUM_W-1:0] req_words_c;
  logic [OFF_W-1:0] start_cnt_c;
  logic [SUM_W-1:0] off_sum_c;
  logic [OFF_W-1:0] start_new_off_c;
  logic [OFF_W-1:0] idx_next_c;
  logic             xfer_c;

  always_comb begin
    req_words_c     = SUM_W'(lines) * SUM_W'(LINE_WORDS);
    start_cnt_c     = (req_words_c >= SUM_W'(FB_WORDS)) ? OFF_W'(FB_WORDS) : req_words_c[OFF_W-1:0];
    off_sum_c       = SUM_W'(cur_offset) + SUM_W'(start_cnt_c);
    start_new_off_c = (off_sum_c >= SUM_W'(FB_WORDS)) ? OFF_W'(off_sum_c - SUM_W'(FB_WORDS))
                                                      : off_sum_c[OFF_W-1:0];
    idx_next_c      = (idx == OFF_W'(FB_WORDS - 1)) ? '0 : idx + OFF_W'(1);
    xfer_c          = bus.m_write & ~bus.m_stall;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    idx_d        = idx;
    pat_d        = pat;
    new_off_d    = new_off;
    cur_offset_d = cur_offset;
    m_write_d    = bus.m_write;
    m_address_d  = bus.m_address;
    m_data_d     = bus.m_data;
    busy_d       = busy;
    done_d       = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          cnt_d     = start_cnt_c;
          idx_d     = cur_offset;
          pat_d     = fill_pattern;
          new_off_d = start_new_off_c;
          busy_d    = 1'b1;
          if (start_cnt_c != '0) begin
            state_d     = CLEAR;
            m_write_d   = 1'b1;
            m_address_d = {8'b0, cur_offset, 2'b00};
            m_data_d    = fill_pattern;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end

      CLEAR: begin
        if (xfer_c) begin
          idx_d = idx_next_c;
          cnt_d = cnt - OFF_W'(1);
          if (cnt == OFF_W'(1)) begin
            state_d     = SETOFF;
            m_address_d = OFF_REG_ADDR;
            m_data_d    = {18'b0, new_off};
          end else begin
            m_address_d = {8'b0, idx_next_c, 2'b00};
          end
        end
      end

      SETOFF: begin
        if (xfer_c) begin
          cur_offset_d = new_off;
          state_d      = DONE;
          m_write_d    = 1'b0;
          done_d       = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d   = IDLE;
        m_write_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      idx           <= '0;
      pat           <= '0;
      new_off       <= '0;
      cur_offset    <= '0;
      bus.m_write   <= 1'b0;
      bus.m_address <= '0;
      bus.m_data    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      idx           <= idx_d;
      pat           <= pat_d;
      new_off       <= new_off_d;
      cur_offset    <= cur_offset_d;
      bus.m_write   <= m_write_d;
      bus.m_address <= m_address_d;
      bus.m_data    <= m_data_d;
      busy          <= busy_d;
      done          <= done_d;
    end
  end

endmodule
